// File: rtl/fetch_pc_unit_pkg.sv
// Shared CPU fetch types: PC layout, fetch FSM states, reset PC and NOP opcode.
package fetch_pc_unit_pkg;

    typedef struct packed {
        logic       bank;
        logic [3:0] page;
        logic [7:0] step;
    } pc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        LATCH = 2'd2
    } fetch_state_t;

    localparam logic [12:0] RESET_PC_DEFAULT = 13'h0100;
    localparam logic [11:0] NOP_OPCODE       = 12'hFFF;

    // Sequential fetch advances PCS only; bank and page never carry.
    function automatic pc_t pc_step_inc(input pc_t cur);
        pc_t nxt;
        nxt      = cur;
        nxt.step = cur.step + 8'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: cycle strobe, ROM port, decode output and execute-stage PC controls.
// The debug pair exists only when FETCH_PC_STEP_EN is defined.
interface fetch_pc_unit_if;
    logic        clk_en;
    logic        fetch_start;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] instr;
    logic        instr_valid;
    logic        busy;
    logic [12:0] pc;
    logic        branch_take;
    logic [7:0]  branch_step;
    logic        pset_valid;
    logic [4:0]  pset_data;
    logic        load_pc;
    logic [12:0] load_value;
    logic        instr_done;
`ifdef FETCH_PC_STEP_EN
    logic        dbg_halt;
    logic        dbg_step;
`endif

    modport master (
        output clk_en, fetch_start, rom_data, branch_take, branch_step,
               pset_valid, pset_data, load_pc, load_value, instr_done,
`ifdef FETCH_PC_STEP_EN
               dbg_halt, dbg_step,
`endif
        input  rom_addr, instr, instr_valid, busy, pc
    );

    modport slave (
        input  clk_en, fetch_start, rom_data, branch_take, branch_step,
               pset_valid, pset_data, load_pc, load_value, instr_done,
`ifdef FETCH_PC_STEP_EN
               dbg_halt, dbg_step,
`endif
        output rom_addr, instr, instr_valid, busy, pc
    );
endinterface

// File: rtl/fetch_pc_unit_page_latch.sv
// NBP/NPP page latches plus the PSET one-shot flag that decides whether the
// next retiring instruction keeps the PSET page or re-syncs it to the PC.
module fetch_pc_unit_page_latch
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [4:0] RESET_PAGE = RESET_PC_DEFAULT[12:8]
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_clk_en,
    input  logic       i_pset_valid,
    input  logic [4:0] i_pset_data,
    input  logic       i_load_pc,
    input  logic [4:0] i_load_page,
    input  logic       i_instr_done,
    input  logic [4:0] i_result_page,
    output logic       o_nbp,
    output logic [3:0] o_npp
);
    logic [4:0] r_page;
    logic       r_armed;
    logic [4:0] w_page_next;
    logic       w_armed_next;

    always_comb begin
        w_page_next  = r_page;
        w_armed_next = r_armed;
        if (i_pset_valid) begin
            w_page_next  = i_pset_data;
            w_armed_next = 1'b1;
        end else begin
            // An armed PSET survives exactly one retirement, then the page tracks the PC again.
            if (i_instr_done) begin
                if (r_armed) begin
                    w_armed_next = 1'b0;
                end else begin
                    w_page_next = i_result_page;
                end
            end
            if (i_load_pc) begin
                w_page_next = i_load_page;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_page  <= RESET_PAGE;
            r_armed <= 1'b0;
        end else if (i_clk_en) begin
            r_page  <= w_page_next;
            r_armed <= w_armed_next;
        end
    end

    assign o_nbp = r_page[4];
    assign o_npp = r_page[3:0];
endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and opcode fetch FSM (IDLE -> WAIT -> LATCH) with branch/call/return loads.
// Define FETCH_PC_STEP_EN to add dbg_halt/dbg_step single-step control.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [12:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FETCH_WAIT = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    fetch_pc_unit_if.slave bus
);
    localparam logic [1:0] WAIT_LAST = 2'(FETCH_WAIT - 1);

    fetch_state_t r_state, w_state_next;
    logic [1:0]   r_cnt, w_cnt_next;
    pc_t          r_pc, w_pc_next;
    logic [12:0]  r_rom_addr, w_rom_addr_next;
    logic [11:0]  r_instr, w_instr_next;
    logic         r_instr_valid, w_instr_valid_next;
    logic         r_busy, w_busy_next;
    logic         w_fetch_go;
    logic         w_nbp;
    logic [3:0]   w_npp;

`ifdef FETCH_PC_STEP_EN
    // While halted, a fetch is released only by a step strobe in the same tick.
    assign w_fetch_go = bus.fetch_start && (!bus.dbg_halt || bus.dbg_step);
`else
    assign w_fetch_go = bus.fetch_start;
`endif

    fetch_pc_unit_page_latch #(
        .RESET_PAGE (RESET_PC[12:8])
    ) u_page_latch (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_clk_en      (bus.clk_en),
        .i_pset_valid  (bus.pset_valid),
        .i_pset_data   (bus.pset_data),
        .i_load_pc     (bus.load_pc),
        .i_load_page   (bus.load_value[12:8]),
        .i_instr_done  (bus.instr_done),
        .i_result_page ({w_pc_next.bank, w_pc_next.page}),
        .o_nbp         (w_nbp),
        .o_npp         (w_npp)
    );

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_pc_next          = r_pc;
        w_rom_addr_next    = r_rom_addr;
        w_instr_next       = r_instr;
        w_instr_valid_next = 1'b0;
        w_busy_next        = r_busy;
        case (r_state)
            IDLE: begin
                if (w_fetch_go) begin
                    w_rom_addr_next = r_pc;
                    w_busy_next     = 1'b1;
                    w_cnt_next      = 2'd0;
                    w_state_next    = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == WAIT_LAST) begin
                    w_state_next = LATCH;
                end else begin
                    w_cnt_next = r_cnt + 2'd1;
                end
            end
            LATCH: begin
                w_instr_next       = bus.rom_data;
                w_instr_valid_next = 1'b1;
                w_busy_next        = 1'b0;
                w_pc_next          = pc_step_inc(r_pc);
                w_state_next       = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        // Execute-stage loads override the sequential increment.
        if (bus.load_pc) begin
            w_pc_next = pc_t'(bus.load_value);
        end else if (bus.branch_take) begin
            w_pc_next = pc_t'({w_nbp, w_npp, bus.branch_step});
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= 2'd0;
            r_pc          <= pc_t'(RESET_PC);
            r_rom_addr    <= RESET_PC;
            r_instr       <= NOP_OPCODE;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else if (bus.clk_en) begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_pc          <= w_pc_next;
            r_rom_addr    <= w_rom_addr_next;
            r_instr       <= w_instr_next;
            r_instr_valid <= w_instr_valid_next;
            r_busy        <= w_busy_next;
        end
    end

    a_no_load_while_fetching: assert property (
        @(posedge clk) disable iff (!reset_n)
        (bus.clk_en && r_state != IDLE) |-> !(bus.load_pc || bus.branch_take)
    );

    assign bus.rom_addr    = r_rom_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.busy        = r_busy;
    assign bus.pc          = r_pc;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed scenarios followed by randomized fetch/execute traffic against a page/PC reference model.
module tb_fetch_pc_unit;
    localparam int FW = 2;

    logic clk = 1'b0;
    logic reset_n;
    int   n_total = 0;
    int   n_pass  = 0;

    logic [11:0] rom_mem [0:8191];

    // Reference model: architectural PC, selected page {NBP,NPP}, pending-PSET flag.
    logic [12:0] m_pc;
    logic [4:0]  m_page;
    bit          m_armed;

    fetch_pc_unit_if bus();
    assign bus.rom_data = rom_mem[bus.rom_addr];

    fetch_pc_unit #(
        .RESET_PC   (13'h0100),
        .FETCH_WAIT (FW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc    = 13'h0100;
        m_page  = 5'h01;
        m_armed = 1'b0;
    endtask

    task automatic do_fetch(input bit rnd);
        logic [12:0] exp_addr;
        int          ticks;
        bit          en;
        bit          seen;
        exp_addr        = m_pc;
        bus.clk_en      = 1'b1;
        bus.fetch_start = 1'b1;
        tick();
        bus.fetch_start = 1'b0;
        check("fetch_rom_addr", bus.rom_addr, exp_addr);
        check("fetch_busy_set", 13'(bus.busy), 13'd1);
        ticks = 0;
        seen  = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            en              = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.clk_en      = en;
            bus.fetch_start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (en) ticks++;
            seen = bus.instr_valid;
        end
        bus.clk_en      = 1'b1;
        bus.fetch_start = 1'b0;
        m_pc = {m_pc[12:8], m_pc[7:0] + 8'd1};
        check("fetch_latency", seen ? 13'(ticks) : 13'd0, 13'(FW + 1));
        check("fetch_instr", 13'(bus.instr), 13'(rom_mem[exp_addr]));
        check("fetch_pc", bus.pc, m_pc);
        check("fetch_busy_clr", 13'(bus.busy), 13'd0);
        tick();
        check("fetch_valid_pulse", 13'(bus.instr_valid), 13'd0);
        check("fetch_addr_hold", bus.rom_addr, exp_addr);
        $display("fetch addr=%h instr=%h pc=%h ticks=%0d", exp_addr, bus.instr, bus.pc, ticks);
    endtask

    task automatic do_exec(input bit ld, input logic [12:0] lv, input bit br,
                           input logic [7:0] st, input bit done);
        logic [12:0] np;
        bus.load_pc     = ld;
        bus.load_value  = lv;
        bus.branch_take = br;
        bus.branch_step = st;
        bus.instr_done  = done;
        tick();
        bus.load_pc     = 1'b0;
        bus.branch_take = 1'b0;
        bus.instr_done  = 1'b0;
        np = ld ? lv : (br ? {m_page, st} : m_pc);
        if (done) begin
            if (m_armed) m_armed = 1'b0;
            else         m_page  = np[12:8];
        end
        if (ld) m_page = lv[12:8];
        m_pc = np;
        check("exec_pc", bus.pc, m_pc);
        $display("exec load=%0b br=%0b step=%h done=%0b pc=%h", ld, br, st, done, bus.pc);
    endtask

    task automatic do_pset(input logic [4:0] d);
        bus.pset_valid = 1'b1;
        bus.pset_data  = d;
        tick();
        bus.pset_valid = 1'b0;
        m_page  = d;
        m_armed = 1'b1;
        check("pset_pc_hold", bus.pc, m_pc);
        $display("pset data=%h pc=%h", d, bus.pc);
    endtask

    initial begin
        bit stray_valid;
        for (int a = 0; a < 8192; a++) rom_mem[a] = 12'($urandom);
        rom_mem[13'h0100] = 12'h2CD;
        reset_n         = 1'b0;
        bus.clk_en      = 1'b1;
        bus.fetch_start = 1'b0;
        bus.branch_take = 1'b0;
        bus.branch_step = 8'h00;
        bus.pset_valid  = 1'b0;
        bus.pset_data   = 5'h00;
        bus.load_pc     = 1'b0;
        bus.load_value  = 13'h0000;
        bus.instr_done  = 1'b0;
`ifdef FETCH_PC_STEP_EN
        bus.dbg_halt    = 1'b0;
        bus.dbg_step    = 1'b0;
`endif
        tick();
        tick();
        reset_n = 1'b1;
        model_reset();

        check("rst_pc", bus.pc, 13'h0100);
        check("rst_rom_addr", bus.rom_addr, 13'h0100);
        check("rst_instr", 13'(bus.instr), 13'h0FFF);
        check("rst_valid", 13'(bus.instr_valid), 13'd0);
        check("rst_busy", 13'(bus.busy), 13'd0);

        do_fetch(1'b0);
        check("t1_instr", 13'(bus.instr), 13'h02CD);
        check("t1_pc", bus.pc, 13'h0101);

        do_exec(1'b0, 13'h0, 1'b1, 8'hCD, 1'b1);
        check("t2_branch", bus.pc, 13'h01CD);

        do_pset(5'h13);
        do_exec(1'b0, 13'h0, 1'b0, 8'h00, 1'b1);
        do_exec(1'b0, 13'h0, 1'b1, 8'h40, 1'b1);
        check("t3_pset_branch", bus.pc, 13'h1340);

        do_exec(1'b1, 13'h0100, 1'b0, 8'h00, 1'b1);
        do_pset(5'h13);
        do_exec(1'b0, 13'h0, 1'b0, 8'h00, 1'b1);
        do_exec(1'b0, 13'h0, 1'b0, 8'h00, 1'b1);
        do_exec(1'b0, 13'h0, 1'b1, 8'h22, 1'b1);
        check("t4_page_restored", bus.pc, 13'h0122);

        do_exec(1'b0, 13'h0, 1'b1, 8'hFF, 1'b1);
        do_fetch(1'b0);
        check("t5_wrap", bus.pc, 13'h0100);
        do_exec(1'b1, 13'h0A35, 1'b0, 8'h00, 1'b1);
        check("t5_load", bus.pc, 13'h0A35);
        do_exec(1'b0, 13'h0, 1'b1, 8'h10, 1'b0);
        check("t5_npp_after_load", bus.pc, 13'h0A10);

        bus.fetch_start = 1'b1;
        tick();
        bus.fetch_start = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        check("t6_busy", 13'(bus.busy), 13'd0);
        check("t6_pc", bus.pc, 13'h0100);
        check("t6_valid", 13'(bus.instr_valid), 13'd0);
        stray_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.instr_valid) stray_valid = 1'b1;
        end
        check("t6_no_valid", 13'(stray_valid), 13'd0);
        do_fetch(1'b0);
        check("t6_refetch_instr", 13'(bus.instr), 13'h02CD);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0, 1: do_fetch(1'b1);
                2:    do_pset(5'($urandom));
                3:    do_exec(1'b0, 13'h0, 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
                4:    do_exec(1'b1, 13'($urandom), 1'b0, 8'h00, 1'b1);
                default: do_exec(1'b0, 13'h0, 1'b0, 8'h00, 1'b1);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
